// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard/forwarding scheduler.
// Result-source codes, forward-mux select codes and the per-stage shadow records.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    WSRC_ALU = 2'b00,
    WSRC_MEM = 2'b01,
    WSRC_PC8 = 2'b10
  } wsrc_e;

  typedef enum logic [3:0] {
    FWD_NONE  = 4'b0000,
    FWD_W     = 4'b0001,
    FWD_M     = 4'b0010,
    FWD_PC8_M = 4'b0011,
    FWD_PC8_E = 4'b0100
  } fwd_e;

  // Tuse value meaning the operand is never read.
  localparam logic [1:0] TUSE_NEVER = 2'd3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] waddr;
    logic [1:0] tnew;
    logic [1:0] wsrc;
    logic       md_start;
    logic       md_div;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] waddr;
    logic [1:0] tnew;
    logic [1:0] wsrc;
  } m_stage_t;

  // Register 0 is hard-wired, so a zero destination never matches.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] waddr);
    return (waddr != 5'd0) && (waddr == r);
  endfunction

  function automatic logic [1:0] tnew_step(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Multiply/divide occupancy counter: loaded when an md start sits in E,
// then counts down to zero; busy also covers the issue cycle itself.
module md_busy_cnt
  #(parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4)
  (input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic div_i,
   output logic busy_o);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign busy_o = (cnt_q != '0) | start_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding scheduler for the 5-stage pipeline: shadows E/M/W
// destination, Tnew and result source to derive stalls and forward selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
  #(parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4)
  (input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic [4:0] d_waddr,
   input  logic [1:0] d_tnew,
   input  logic [1:0] d_wsrc,
   input  logic       d_is_md,
   input  logic       d_md_start,
   input  logic       d_md_div,
   output logic       stall,
   output logic [3:0] fwd_rs_d,
   output logic [3:0] fwd_rt_d,
   output logic [3:0] fwd_rs_e,
   output logic [3:0] fwd_rt_e,
   output logic       fwd_rt_m,
   output logic       md_busy,
   output logic       pc_init);

  e_stage_t   e_q, e_d;
  m_stage_t   m_q, m_d;
  logic [4:0] w_waddr_q;
  logic       pc_init_q;

  function automatic logic src_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                      input e_stage_t e, input m_stage_t m);
    return (tuse != TUSE_NEVER) &&
           ((reg_match(r, e.waddr) && (e.tnew > tuse)) ||
            (reg_match(r, m.waddr) && (m.tnew > tuse)));
  endfunction

  // A matching stage whose result is not yet ready falls through to older
  // stages; the consumer then picks the right value up in a later stage.
  function automatic fwd_e fwd_pick(input logic [4:0] r, input logic use_e,
                                    input e_stage_t e, input m_stage_t m,
                                    input logic [4:0] w_waddr);
    if (use_e && reg_match(r, e.waddr) && (e.tnew == 2'd0) && (e.wsrc == WSRC_PC8))
      return FWD_PC8_E;
    if (reg_match(r, m.waddr) && (m.tnew == 2'd0))
      return (m.wsrc == WSRC_PC8) ? FWD_PC8_M : FWD_M;
    if (reg_match(r, w_waddr))
      return FWD_W;
    return FWD_NONE;
  endfunction

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .clk     (clk),
    .rst     (reset),
    .start_i (e_q.md_start),
    .div_i   (e_q.md_div),
    .busy_o  (md_busy)
  );

  always_comb begin
    stall = src_hazard(d_rs, d_tuse_rs, e_q, m_q) |
            src_hazard(d_rt, d_tuse_rt, e_q, m_q) |
            (d_is_md & md_busy);
  end

  always_comb begin
    fwd_rs_d = fwd_pick(d_rs, 1'b1, e_q, m_q, w_waddr_q);
    fwd_rt_d = fwd_pick(d_rt, 1'b1, e_q, m_q, w_waddr_q);
    fwd_rs_e = fwd_pick(e_q.rs, 1'b0, e_q, m_q, w_waddr_q);
    fwd_rt_e = fwd_pick(e_q.rt, 1'b0, e_q, m_q, w_waddr_q);
    fwd_rt_m = reg_match(m_q.rt, w_waddr_q);
  end

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs       = d_rs;
      e_d.rt       = d_rt;
      e_d.waddr    = d_waddr;
      e_d.tnew     = d_tnew;
      e_d.wsrc     = d_wsrc;
      e_d.md_start = d_md_start;
      e_d.md_div   = d_md_div;
    end
    m_d.rt    = e_q.rt;
    m_d.waddr = e_q.waddr;
    m_d.tnew  = tnew_step(e_q.tnew);
    m_d.wsrc  = e_q.wsrc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q       <= '0;
      m_q       <= '0;
      w_waddr_q <= '0;
      pc_init_q <= 1'b1;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      w_waddr_q <= m_q.waddr;
      pc_init_q <= 1'b0;
    end
  end

  assign pc_init = pc_init_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of per-cycle D inputs with expected
// outputs, plus hand-written md-busy and reset sequences.
module tb_hazard_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_wsrc;
  logic       d_is_md, d_md_start, d_md_div;
  logic       stall, fwd_rt_m, md_busy, pc_init;
  logic [3:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MULT_CYC (MULT_N),
    .DIV_CYC  (DIV_N),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_waddr    (d_waddr),
    .d_tnew     (d_tnew),
    .d_wsrc     (d_wsrc),
    .d_is_md    (d_is_md),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .stall      (stall),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .fwd_rt_m   (fwd_rt_m),
    .md_busy    (md_busy),
    .pc_init    (pc_init)
  );

  typedef struct {
    logic [4:0]  rs, rt, wa;
    logic [1:0]  tu_rs, tu_rt, tnew, wsrc;
    logic        is_md, st, dv;
    logic [19:0] exp;
  } vec_t;

  int   nvec = 0;
  int   nbad = 0;
  vec_t tbl[$];
  vec_t v_nop, v_div, v_mult, v_mflo, v_mfhi;
  logic [19:0] outs;

  assign outs = {pc_init, stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy};

  function automatic logic [19:0] ex(input logic pc, input logic st,
                                     input logic [3:0] rsd, input logic [3:0] rtd,
                                     input logic [3:0] rse, input logic [3:0] rte,
                                     input logic rtm, input logic bz);
    return {pc, st, rsd, rtd, rse, rte, rtm, bz};
  endfunction

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                              input logic [4:0] wa, input logic [1:0] tnew,
                              input logic [1:0] wsrc, input logic is_md,
                              input logic st, input logic dv, input logic [19:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.tu_rs = tu_rs; v.tu_rt = tu_rt; v.wa = wa;
    v.tnew = tnew; v.wsrc = wsrc; v.is_md = is_md; v.st = st; v.dv = dv; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    d_rs = v.rs; d_rt = v.rt; d_tuse_rs = v.tu_rs; d_tuse_rt = v.tu_rt;
    d_waddr = v.wa; d_tnew = v.tnew; d_wsrc = v.wsrc;
    d_is_md = v.is_md; d_md_start = v.st; d_md_div = v.dv;
  endtask

  task automatic check(input string nm, input logic [19:0] exp);
    nvec++;
    if (outs !== exp) begin
      nbad++;
      $display("FAIL %s: got %b expected %b (pc_init,stall,rs_d,rt_d,rs_e,rt_e,rt_m,busy)",
               nm, outs, exp);
    end
  endtask

  localparam logic [19:0] Z  = 20'b0;
  localparam logic [19:0] ZP = {1'b1, 19'b0};

  initial begin
    v_nop  = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, Z);
    v_div  = mk(4, 5, 1, 1, 0, 0, 0, 1, 1, 1, Z);
    v_mult = mk(4, 5, 1, 1, 0, 0, 0, 1, 1, 0, Z);
    v_mflo = mk(0, 0, 3, 3, 10, 1, 0, 1, 0, 0, Z);
    v_mfhi = mk(0, 0, 3, 3, 11, 1, 0, 1, 0, 0, Z);

    // Load-use: lw $8 then add reading $8 in E.
    tbl.push_back(mk(29, 0, 1, 3, 8, 2, 1, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(8, 10, 1, 1, 9, 1, 0, 0, 0, 0, ex(0,1,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(8, 10, 1, 1, 9, 1, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0001,4'b0000,0,0)));
    // jal then jr $31 in D, then PC8 from M and from W.
    tbl.push_back(mk(0, 0, 3, 3, 31, 0, 2, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(31, 0, 0, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0100,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0011,4'b0000,0,0)));
    tbl.push_back(mk(31, 0, 1, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0001,4'b0000,4'b0000,4'b0000,0,0)));
    // Two addu $8 back to back; newest (M) wins, $0 never forwards.
    tbl.push_back(mk(1, 2, 1, 1, 8, 1, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(1, 2, 1, 1, 8, 1, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(8, 8, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0010,4'b0010,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0001,4'b0001,0,0)));
    // lw $9 then sw $9: store data forwarded from W into M.
    tbl.push_back(mk(29, 0, 1, 3, 9, 2, 1, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(29, 9, 1, 2, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,1,0)));
    // ALU result needed in D (tuse 0): one stall, then M forward, then W to E.
    tbl.push_back(mk(0, 0, 3, 3, 12, 1, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(12, 0, 0, 3, 0, 0, 0, 0, 0, 0, ex(0,1,4'b0000,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(12, 0, 0, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0010,4'b0000,4'b0000,4'b0000,0,0)));
    tbl.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, ex(0,0,4'b0000,4'b0000,4'b0001,4'b0000,0,0)));

    // Reset with hazard-looking D inputs: outputs quiet, pc_init high.
    drive(mk(8, 8, 0, 0, 8, 2, 1, 1, 1, 1, Z));
    #1 reset = 1'b1;
    #2 check("reset_state", ZP);
    @(posedge clk); #1 check("reset_hold", ZP);
    drive(v_nop);
    @(negedge clk); reset = 1'b0;
    #1 check("pc_init_after_release", ZP);
    @(posedge clk); #1 check("pc_init_fall", Z);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 check($sformatf("row%0d", i), tbl[i].exp);
    end

    // div in E, mflo waiting in D: issue cycle plus DIV_N counted cycles.
    @(negedge clk); drive(v_div); #1 check("div_issue", Z);
    for (int i = 0; i <= int'(DIV_N); i++) begin
      @(negedge clk); drive(v_mflo);
      #1 check($sformatf("div_busy%0d", i), ex(0,1,4'b0000,4'b0000,4'b0000,4'b0000,0,1));
    end
    @(negedge clk); #1 check("div_done", Z);

    @(negedge clk); drive(v_mult); #1 check("mult_issue", Z);
    for (int i = 0; i <= int'(MULT_N); i++) begin
      @(negedge clk); drive(v_mfhi);
      #1 check($sformatf("mult_busy%0d", i), ex(0,1,4'b0000,4'b0000,4'b0000,4'b0000,0,1));
    end
    @(negedge clk); #1 check("mult_done", Z);

    // Second divide, reset asynchronously with the counter at 3 and a stall pending.
    @(negedge clk); drive(v_div); #1 check("div2_issue", Z);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk); drive(v_mflo);
      #1 check($sformatf("div2_busy%0d", i), ex(0,1,4'b0000,4'b0000,4'b0000,4'b0000,0,1));
    end
    #2 reset = 1'b1;
    #1 check("reset_mid_md", ZP);
    @(negedge clk); reset = 1'b0; drive(v_nop);
    #1 check("rerelease_pc_init_hold", ZP);
    @(posedge clk); #1 check("rerelease_pc_init_fall", Z);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
